// File: rtl/fnn_pkg.sv
// Shared types and arithmetic helpers for the FNN layers.
package fnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int SAT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed add clamped to a w-bit range; operands must already fit in w bits (w <= 62),
  // so the 64-bit sum never overflows before the clamp.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int unsigned                 w
  );
    logic signed [SAT_MAX_W-1:0] sum;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 32'd1));
    if (sum > hi) begin
      sat_add = hi;
    end else if (sum < lo) begin
      sat_add = lo;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/score_layer_weight_ram.sv
// Weight storage: one write port, one registered read port, no reset on contents.
module weight_ram #(
  parameter int depth = 32,
  parameter int width = 160
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width-1:0]         wr_data,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data
);

  logic [width-1:0] mem [depth];

  // Write port and one-cycle registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/score_layer.sv
// Final fully-connected layer: weightNo saturating dot products plus bias,
// one input element per cycle, all neurons in parallel.
module score_layer
  import fnn_pkg::*;
#(
  parameter int inputNo   = 32,
  parameter int weightNo  = 10,
  parameter int dataWidth = DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              done_in,
  input  logic [inputNo*dataWidth-1:0]      in,
  input  logic                              w_we,
  input  logic [$clog2(inputNo)-1:0]        w_addr,
  input  logic [weightNo*dataWidth-1:0]     w_data,
  input  logic                              b_we,
  input  logic [$clog2(weightNo)-1:0]       b_addr,
  input  logic [2*dataWidth-1:0]            b_data,
  output logic                              done_out,
  output logic [weightNo*2*dataWidth-1:0]   out
);

  localparam int AW    = $clog2(inputNo);
  localparam int ACC_W = 2 * dataWidth;

  state_t                         state;
  logic                           armed;
  logic [inputNo*dataWidth-1:0]   x_reg;
  logic signed [ACC_W-1:0]        acc      [weightNo];
  logic signed [ACC_W-1:0]        bias     [weightNo];
  logic signed [ACC_W-1:0]        acc_next [weightNo];
  logic signed [ACC_W-1:0]        prod     [weightNo];
  logic signed [dataWidth-1:0]    xk;
  logic [AW-1:0]                  rd_addr;
  logic [AW-1:0]                  rd_idx;
  logic                           rd_valid;
  logic                           issue_done;
  logic [weightNo*dataWidth-1:0]  rd_data;
  logic                           load_ok;

  // Loads are only honoured outside a run so a run's coefficients never change under it.
  assign load_ok = (state != MAC);

  weight_ram #(
    .depth (inputNo),
    .width (weightNo * dataWidth)
  ) u_weight_ram (
    .clk     (clk),
    .we      (w_we && load_ok),
    .wr_addr (w_addr),
    .wr_data (w_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Bias register array; contents are not reset.
  always_ff @(posedge clk) begin
    if (b_we && load_ok && (int'(b_addr) < weightNo)) begin
      bias[b_addr] <= $signed(b_data);
    end
  end

  // Next accumulator value for the element whose weights are on rd_data.
  always_comb begin
    xk = $signed(x_reg[rd_idx*dataWidth +: dataWidth]);
    for (int j = 0; j < weightNo; j++) begin
      prod[j]     = xk * $signed(rd_data[j*dataWidth +: dataWidth]);
      acc_next[j] = ACC_W'(sat_add(SAT_MAX_W'(acc[j]), SAT_MAX_W'(prod[j]), ACC_W));
    end
  end

  // Control FSM, address issue, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      done_out   <= 1'b0;
      out        <= '0;
      x_reg      <= '0;
      rd_addr    <= '0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      issue_done <= 1'b0;
      for (int j = 0; j < weightNo; j++) begin
        acc[j] <= '0;
      end
    end else begin
      if (!done_in) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (armed && done_in) begin
            x_reg      <= in;
            rd_addr    <= '0;
            rd_valid   <= 1'b0;
            issue_done <= 1'b0;
            armed      <= 1'b0;
            state      <= MAC;
            for (int j = 0; j < weightNo; j++) begin
              acc[j] <= bias[j];
            end
          end
        end
        MAC: begin
          // rd_valid/rd_idx track the read issued this edge, landing one cycle later.
          rd_valid <= !issue_done;
          rd_idx   <= rd_addr;
          if (rd_addr == AW'(inputNo - 1)) begin
            issue_done <= 1'b1;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
          if (rd_valid) begin
            for (int j = 0; j < weightNo; j++) begin
              acc[j] <= acc_next[j];
            end
            if (rd_idx == AW'(inputNo - 1)) begin
              for (int j = 0; j < weightNo; j++) begin
                out[j*ACC_W +: ACC_W] <= acc_next[j];
              end
              done_out <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (!done_in) begin
            done_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_layer.sv
// Self-checking bench for score_layer with a saturating dot-product reference model.
module tb_score_layer;

  localparam int IN = 4;
  localparam int WN = 3;
  localparam int DW = 8;
  localparam int SW = 2 * DW;
  localparam int AW = $clog2(IN);
  localparam int BW = $clog2(WN);

  logic              clk = 1'b0;
  logic              rst;
  logic              done_in;
  logic [IN*DW-1:0]  in;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [WN*DW-1:0]  w_data;
  logic              b_we;
  logic [BW-1:0]     b_addr;
  logic [SW-1:0]     b_data;
  logic              done_out;
  logic [WN*SW-1:0]  out;

  int wm [IN][WN];
  int bm [WN];
  int xm [IN];
  int checks = 0;
  int passes = 0;

  score_layer #(.inputNo(IN), .weightNo(WN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .in(in),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .done_out(done_out), .out(out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bias, then each product added with a clamp to the score range.
  function automatic longint model_score(int j);
    longint acc;
    longint hi;
    longint lo;
    hi  = (longint'(1) <<< (SW - 1)) - 1;
    lo  = -hi - 1;
    acc = bm[j];
    for (int k = 0; k < IN; k++) begin
      acc = acc + longint'(xm[k]) * longint'(wm[k][j]);
      if (acc > hi) acc = hi;
      else if (acc < lo) acc = lo;
    end
    return acc;
  endfunction

  function automatic longint dut_score(logic [WN*SW-1:0] bus, int j);
    logic signed [SW-1:0] s;
    s = bus[j*SW +: SW];
    return longint'(s);
  endfunction

  function automatic int rnd_data();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int rnd_bias();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic randomize_model();
    for (int k = 0; k < IN; k++) begin
      xm[k] = rnd_data();
      for (int j = 0; j < WN; j++) wm[k][j] = rnd_data();
    end
    for (int j = 0; j < WN; j++) bm[j] = rnd_bias();
  endtask

  task automatic set_x();
    for (int k = 0; k < IN; k++) in[k*DW +: DW] = DW'(xm[k]);
  endtask

  task automatic load_all();
    for (int k = 0; k < IN; k++) begin
      w_we   = 1'b1;
      w_addr = AW'(k);
      for (int j = 0; j < WN; j++) w_data[j*DW +: DW] = DW'(wm[k][j]);
      tick();
    end
    w_we = 1'b0;
    for (int j = 0; j < WN; j++) begin
      b_we   = 1'b1;
      b_addr = BW'(j);
      b_data = SW'(bm[j]);
      tick();
    end
    b_we = 1'b0;
    set_x();
  endtask

  // Raises done_in and returns edges from the start edge to done_out, or -1.
  task automatic run_and_wait(output int lat);
    done_in = 1'b1;
    lat = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done_out) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic drop_done();
    done_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; done_in = 1'b0; w_we = 1'b0; b_we = 1'b0;
    w_addr = '0; w_data = '0; b_addr = '0; b_data = '0; in = '0;
    tick(); tick();
    checks++;
    if (done_out !== 1'b0) $display("FAIL reset_done_out: got %b want 0", done_out);
    else passes++;
    checks++;
    if (out !== '0) $display("FAIL reset_out: got %h want 0", out);
    else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int lat;
    int best;
    xm = '{1, 2, 3, 4};
    for (int k = 0; k < IN; k++)
      for (int j = 0; j < WN; j++) wm[k][j] = j + 1;
    bm = '{0, 10, -5};
    load_all();
    run_and_wait(lat);
    checks++;
    if (lat !== IN + 1) $display("FAIL directed_latency: got %0d want %0d", lat, IN + 1);
    else passes++;
    for (int j = 0; j < WN; j++) begin
      checks++;
      if (dut_score(out, j) !== model_score(j))
        $display("FAIL directed_score%0d: got %0d want %0d", j, dut_score(out, j), model_score(j));
      else passes++;
    end
    best = 0;
    for (int j = 1; j < WN; j++)
      if (dut_score(out, j) > dut_score(out, best)) best = j;
    checks++;
    if (best !== 1) $display("FAIL directed_argmax: got %0d want 1", best);
    else passes++;
    drop_done();
  endtask

  task automatic test_saturation();
    int lat;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < IN; k++) begin
        xm[k] = 127;
        for (int j = 0; j < WN; j++) wm[k][j] = (pass == 0) ? 127 : -128;
      end
      for (int j = 0; j < WN; j++) bm[j] = (pass == 0) ? 32767 : 0;
      load_all();
      run_and_wait(lat);
      for (int j = 0; j < WN; j++) begin
        checks++;
        if (dut_score(out, j) !== model_score(j))
          $display("FAIL sat%0d_score%0d: got %0d want %0d", pass, j, dut_score(out, j), model_score(j));
        else passes++;
      end
      drop_done();
    end
  endtask

  task automatic test_handshake();
    int lat;
    logic [WN*SW-1:0] held;
    logic bad;
    randomize_model();
    load_all();
    run_and_wait(lat);
    held = out;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_out !== 1'b1 || out !== held) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL hold_no_restart: got done_out=%b out=%h want 1 and %h", done_out, out, held);
    else passes++;
    done_in = 1'b0;
    tick();
    checks++;
    if (done_out !== 1'b0) $display("FAIL drop_done_out: got %b want 0", done_out);
    else passes++;
    for (int k = 0; k < IN; k++) xm[k] = rnd_data();
    set_x();
    run_and_wait(lat);
    checks++;
    if (lat !== IN + 1) $display("FAIL rerun_latency: got %0d want %0d", lat, IN + 1);
    else passes++;
    for (int j = 0; j < WN; j++) begin
      checks++;
      if (dut_score(out, j) !== model_score(j))
        $display("FAIL rerun_score%0d: got %0d want %0d", j, dut_score(out, j), model_score(j));
      else passes++;
    end
    drop_done();
  endtask

  task automatic test_early_drop();
    int highs;
    logic [WN*SW-1:0] seen;
    randomize_model();
    load_all();
    done_in = 1'b1;
    tick();
    in = {$urandom(), $urandom()};
    tick();
    done_in = 1'b0;
    highs = 0;
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_out) begin
        highs++;
        seen = out;
      end
    end
    checks++;
    if (highs !== 1) $display("FAIL early_drop_pulse: got %0d cycles want 1", highs);
    else passes++;
    for (int j = 0; j < WN; j++) begin
      checks++;
      if (dut_score(seen, j) !== model_score(j))
        $display("FAIL early_drop_score%0d: got %0d want %0d", j, dut_score(seen, j), model_score(j));
      else passes++;
    end
  endtask

  task automatic test_write_block();
    int lat;
    randomize_model();
    load_all();
    done_in = 1'b1;
    tick();
    tick();
    w_we = 1'b1; w_data = '0; b_we = 1'b1; b_data = '0;
    w_addr = AW'(0); b_addr = BW'(0);
    tick();
    w_addr = AW'(IN - 1); b_addr = BW'(1);
    tick();
    w_we = 1'b0; b_we = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (done_out) begin
        lat = c;
        break;
      end
      tick();
    end
    checks++;
    if (lat < 0) $display("FAIL wblock_timeout: got no done_out want done_out");
    else passes++;
    for (int j = 0; j < WN; j++) begin
      checks++;
      if (dut_score(out, j) !== model_score(j))
        $display("FAIL wblock_score%0d: got %0d want %0d", j, dut_score(out, j), model_score(j));
      else passes++;
    end
    drop_done();
    run_and_wait(lat);
    for (int j = 0; j < WN; j++) begin
      checks++;
      if (dut_score(out, j) !== model_score(j))
        $display("FAIL wblock_next_score%0d: got %0d want %0d", j, dut_score(out, j), model_score(j));
      else passes++;
    end
    drop_done();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic bad;
    randomize_model();
    load_all();
    done_in = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (done_out !== 1'b0) $display("FAIL midrst_done_out: got %b want 0", done_out);
    else passes++;
    checks++;
    if (out !== '0) $display("FAIL midrst_out: got %h want 0", out);
    else passes++;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done_out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL midrst_no_restart: got done_out=1 want 0");
    else passes++;
    drop_done();
    run_and_wait(lat);
    checks++;
    if (lat !== IN + 1) $display("FAIL midrst_latency: got %0d want %0d", lat, IN + 1);
    else passes++;
    for (int j = 0; j < WN; j++) begin
      checks++;
      if (dut_score(out, j) !== model_score(j))
        $display("FAIL midrst_score%0d: got %0d want %0d", j, dut_score(out, j), model_score(j));
      else passes++;
    end
    drop_done();
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 6; it++) begin
      randomize_model();
      load_all();
      run_and_wait(lat);
      for (int j = 0; j < WN; j++) begin
        checks++;
        if (dut_score(out, j) !== model_score(j))
          $display("FAIL random%0d_score%0d: got %0d want %0d", it, j, dut_score(out, j), model_score(j));
        else passes++;
      end
      drop_done();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_handshake();
    test_early_drop();
    test_write_block();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/score_layer.md
# score_layer

Final fully-connected layer of the FNN. Takes the activated vector from the previous hidden layer and computes `weightNo` signed dot products plus bias, one input element per cycle, with all neurons in parallel. Its packed score bus and `done_out` level feed the arg-max classifier `output_layer` directly: `in` and `done_in` there respectively. Weights and biases live in on-chip RAM written through a simple load port.

## Interface
- `inputNo`, 32: elements in the input vector.
- `weightNo`, 10: neurons / output scores.
- `dataWidth`, 16: width of inputs and weights, signed two's complement; scores are `2*dataWidth`.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `done_in` input 1: level from previous layer; high = `in` valid and stable.
- `in` input `inputNo*dataWidth`: element k at `[k*dataWidth +: dataWidth]`.
- `w_we` input 1: weight write strobe.
- `w_addr` input `$clog2(inputNo)`: input index k.
- `w_data` input `weightNo*dataWidth`: weights of element k for all neurons, neuron j at `[j*dataWidth +: dataWidth]`.
- `b_we` input 1: bias write strobe.
- `b_addr` input `$clog2(weightNo)`: neuron index.
- `b_data` input `2*dataWidth`: bias.
- `done_out` output 1: level; high = `out` valid.
- `out` output `weightNo*2*dataWidth`: score j at `[j*2*dataWidth +: 2*dataWidth]`.

## Operation
- FSM states: IDLE, MAC, DONE.
- `armed` flag:
  - set on any edge where `done_in`=0;
  - cleared on start.
- Start: IDLE & `armed` & `done_in`=1.
  - capture `in` into an internal register;
  - `acc[j]` <= `bias[j]`;
  - `rd_addr` <= 0;
  - clear `armed`;
  - go to MAC.
- MAC:
  - `rd_addr` increments each cycle up to `inputNo-1`, then holds.
  - Weight RAM read is registered (1 cycle).
  - Each valid read word performs `acc[j]` <= sat(`acc[j]` + `x[k]*w[j][k]`) for all j.
- Arithmetic:
  - product is a full `2*dataWidth` signed value;
  - the sum is formed in `2*dataWidth+1` bits, then clamped to [-2^(2dw-1), 2^(2dw-1)-1] on every add.
- After element `inputNo-1` is accumulated:
  - `out` <= acc;
  - `done_out` <= 1;
  - go to DONE.
- DONE:
  - stays at least one cycle;
  - on `done_in`=0: `done_out` <= 0 and go to IDLE (that edge also sets `armed`).
  - `out` holds its value until the next DONE entry or reset.
- `done_in` dropping mid-MAC:
  - the run completes on the captured vector;
  - DONE lasts exactly one cycle.
- Load ports:
  - writes are accepted only in IDLE or DONE;
  - writes in MAC are silently dropped, so weights used by a run never change mid-run.

## Timing
- Start edge E0. Element k is accumulated at edge E(k+2).
- `done_out` rises after edge E(`inputNo`+1): latency `inputNo`+1 cycles.
- `done_out` falls on the first edge in DONE where `done_in`=0.
- Minimum gap between a `done_out` fall and the next start: 1 cycle (IDLE).
- Reset values (any state, including mid-MAC, which aborts the run):
  - state IDLE, `armed`=0, `done_out`=0, `out`=0, `acc`=0, `rd_addr`=0.
- Weight and bias RAM contents are not reset.
- A `done_in` already high out of reset does not start a run; it must be seen low first.
- Write and read of the same address in the same cycle cannot occur: writes are blocked in MAC.

## Structure
- Shared package `fnn_pkg` holds:
  - the `state_t` enum (IDLE, MAC, DONE);
  - `sat_add` function, parameterised via width localparams;
  - default `dataWidth`.
- Sub-module `weight_ram`:
  - `inputNo` deep, `weightNo*dataWidth` wide;
  - one write port, one registered read port.
- Bias is a register array in `score_layer`.

## Test plan
- Directed accumulate, with `inputNo`=4, `weightNo`=3, `dataWidth`=8:
  - load x={1,2,3,4}, w[j][k]=j+1, bias={0,10,-5};
  - required: `out`={10,30,25} with `done_out` high exactly 5 cycles after start;
  - feeding `output_layer` then gives 1.
- Saturation:
  - x all 127, w all 127, bias 32767 at `dataWidth`=8;
  - required: score clamps to 32767;
  - with w all -128, score clamps to -32768, no wrap.
- Handshake:
  - hold `done_in` high after DONE: no restart and `done_out` stays high;
  - drop `done_in`: `done_out` falls on the same edge;
  - raise `done_in` again: new run, new latency identical.
- Early drop:
  - pulse `done_in` high for 2 cycles;
  - required: full result still produced, `done_out` high for exactly 1 cycle.
- Write blocking:
  - issue `w_we` with all-zero data during MAC;
  - required: result equals the no-write reference, and the next run also matches it (write dropped).
- Reset:
  - assert `rst` mid-MAC with `done_in` held high;
  - required: `done_out`=0 and `out`=0 next cycle, and no run until `done_in` cycles low then high.
